// File: rtl/button_event_detector.sv
// Turns a debounced, same-clock button level into press/release/long/repeat
// pulses, a held level and a wrapping press counter. All outputs registered.
module button_event_detector #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 26
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_Data,
    output logic       o_Press,
    output logic       o_Release,
    output logic       o_Long,
    output logic       o_Repeat,
    output logic       o_Held,
    output logic [7:0] o_Press_Count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        held_d      = held_q;
        press_cnt_d = press_cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_Data) begin
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                    cnt_d       = '0;
                    held_d      = 1'b1;
                    state_d     = ST_PRESS;
                end
            end
            ST_PRESS: begin
                // Release is checked first so it wins over a same-edge long decision.
                if (!i_Data) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!i_Data) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                held_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign o_Press       = press_q;
    assign o_Release     = release_q;
    assign o_Long        = long_q;
    assign o_Repeat      = repeat_q;
    assign o_Held        = held_q;
    assign o_Press_Count = press_cnt_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Self-checking bench for button_event_detector: directed scenarios plus random
// stimulus, compared against a press-duration model of the event rules.
module tb_button_event_detector;

    localparam int L = 4;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data = 1'b0;
    logic       o_press, o_release, o_long, o_repeat, o_held;
    logic [7:0] o_cnt;

    int total = 0;
    int bad   = 0;

    // Model: whether a press is in progress and how many edges since it began.
    bit       m_in;
    int       m_n;
    logic     m_press, m_release, m_long, m_repeat, m_held;
    logic [7:0] m_cnt;

    button_event_detector #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (4)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_Data       (data),
        .o_Press      (o_press),
        .o_Release    (o_release),
        .o_Long       (o_long),
        .o_Repeat     (o_repeat),
        .o_Held       (o_held),
        .o_Press_Count(o_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] dut_vec();
        return {o_press, o_release, o_long, o_repeat, o_held, o_cnt};
    endfunction

    function automatic logic [12:0] mdl_vec();
        return {m_press, m_release, m_long, m_repeat, m_held, m_cnt};
    endfunction

    task automatic model_edge(input logic r, input logic d);
        m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
        if (r) begin
            m_in = 0; m_n = 0; m_held = 0; m_cnt = 8'd0;
        end else if (!m_in) begin
            if (d) begin
                m_in = 1; m_n = 0; m_press = 1; m_held = 1; m_cnt = m_cnt + 8'd1;
            end
        end else if (!d) begin
            m_in = 0; m_release = 1; m_held = 0;
        end else begin
            m_n++;
            if (m_n == L) m_long = 1;
            else if (m_n > L && (m_n - L) % R == 0) m_repeat = 1;
        end
    endtask

    // Apply inputs, let one rising edge sample them, then settle before checks.
    task automatic tick(input logic r, input logic d);
        rst  = r;
        data = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            total++;
            if (dut_vec() !== 13'd0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %b required %b", i, dut_vec(), 13'd0);
            end
        end
        tick(1'b0, 1'b1);
        total++;
        if (o_press !== 1'b1 || o_cnt !== 8'd1 || o_held !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_press: press=%b cnt=%0d held=%b required 1/1/1", o_press, o_cnt, o_held);
        end
        tick(1'b0, 1'b0);
        total++;
        if (o_press !== 1'b0 || dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL reset_press_width: got %b required %b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_short_press();
        int np, nl, nr;
        logic [7:0] c0;
        np = 0; nl = 0; nr = 0;
        tick(1'b0, 1'b0);
        c0 = o_cnt;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, i < 3);
            np += int'(o_press); nl += int'(o_long); nr += int'(o_release);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL short_press[%0d]: got %b required %b", i, dut_vec(), mdl_vec());
            end
            if (i == 3) begin
                total++;
                if (o_release !== 1'b1) begin
                    bad++;
                    $display("FAIL short_release_timing: got %b required 1", o_release);
                end
            end
        end
        total++;
        if (np != 1 || nl != 0 || nr != 1 || o_held !== 1'b0 || o_cnt !== c0 + 8'd1) begin
            bad++;
            $display("FAIL short_summary: press=%0d long=%0d rel=%0d held=%b cnt=%0d required 1/0/1/0/%0d",
                     np, nl, nr, o_held, o_cnt, c0 + 8'd1);
        end
    endtask

    task automatic test_long_repeat();
        logic [3:0] exp;
        tick(1'b0, 1'b0);
        for (int i = 0; i <= 17; i++) begin
            tick(1'b0, i < 14);
            exp = {i == 0, i == 14, i == 4, i == 7 || i == 10 || i == 13};
            total++;
            if ({o_press, o_release, o_long, o_repeat} !== exp || dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL long_repeat[k+%0d]: got %b required pulses %b model %b", i, dut_vec(), exp, mdl_vec());
            end
        end
    endtask

    task automatic test_collision();
        int nl;
        nl = 0;
        tick(1'b0, 1'b0);
        for (int i = 0; i <= 6; i++) begin
            tick(1'b0, i < 4);
            nl += int'(o_long);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL collision[k+%0d]: got %b required %b", i, dut_vec(), mdl_vec());
            end
            if (i == 4) begin
                total++;
                if (o_release !== 1'b1 || o_held !== 1'b0) begin
                    bad++;
                    $display("FAIL collision_release: rel=%b held=%b required 1/0", o_release, o_held);
                end
            end
        end
        total++;
        if (nl != 0) begin
            bad++;
            $display("FAIL collision_no_long: got %0d long pulses required 0", nl);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int np, nr;
        np = 0; nr = 0;
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            tick(1'b0, 1'b1);
            np += int'(o_press);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL wrap_press[%0d]: got %b required %b", i, dut_vec(), mdl_vec());
            end
            if (i == 255 || i == 256) begin
                total++;
                if (o_cnt !== ((i == 255) ? 8'd255 : 8'd0)) begin
                    bad++;
                    $display("FAIL wrap_count[%0d]: got %0d required %0d", i, o_cnt, (i == 255) ? 255 : 0);
                end
            end
            tick(1'b0, 1'b0);
            nr += int'(o_release);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL wrap_release[%0d]: got %b required %b", i, dut_vec(), mdl_vec());
            end
        end
        total++;
        if (np != 256 || nr != 256) begin
            bad++;
            $display("FAIL wrap_pulses: press=%0d rel=%0d required 256/256", np, nr);
        end
    endtask

    task automatic test_reset_mid_hold();
        tick(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
        total++;
        if (o_held !== 1'b1 || dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL midhold_pre: got %b required %b", dut_vec(), mdl_vec());
        end
        tick(1'b1, 1'b1);
        total++;
        if (dut_vec() !== 13'd0) begin
            bad++;
            $display("FAIL midhold_reset: got %b required %b", dut_vec(), 13'd0);
        end
        tick(1'b0, 1'b1);
        total++;
        if (o_press !== 1'b1 || o_cnt !== 8'd1 || o_release !== 1'b0) begin
            bad++;
            $display("FAIL midhold_repress: press=%b cnt=%0d rel=%b required 1/1/0", o_press, o_cnt, o_release);
        end
    endtask

    task automatic test_random();
        logic d, r;
        d = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 2) d = ~d;
            r = ($urandom_range(0, 99) == 0);
            tick(r, d);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got %b required %b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        m_in = 0; m_n = 0; m_cnt = 0; m_held = 0;
        m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
        test_reset();
        test_short_press();
        test_long_repeat();
        test_collision();
        test_back_to_back_wrap();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_detector.md
Name: button_event_detector

Overview:
- Sits directly downstream of the button debouncer.
- Consumes its clean, same-clock level output and turns it into discrete user-input events for the CPU front panel / control logic:
  - single-cycle press and release pulses;
  - a long-press pulse;
  - periodic auto-repeat pulses while the button stays held;
  - a wrapping press counter.
- No synchronisation or debouncing is done here; the input is already debounced and in the i_CLK domain.

Parameters:
- LONG_CYCLES, 50000000, number of cycles the level must stay high after press detection before o_Long fires (1 s at 50 MHz); legal range >= 2.
- REPEAT_CYCLES, 10000000, auto-repeat period in cycles once in HELD (200 ms at 50 MHz); legal range >= 1.
- CNT_W, 26, width of the internal cycle counter; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- i_CLK  input  1  system clock; all logic on the rising edge.
- i_RST  input  1  synchronous, active-high reset.
- i_Data  input  1  debounced button level from the debouncer (1 = pressed).
- o_Press  output  1  one-cycle pulse on press detection.
- o_Release  output  1  one-cycle pulse on release detection.
- o_Long  output  1  one-cycle pulse when the press qualifies as long.
- o_Repeat  output  1  one-cycle pulse every REPEAT_CYCLES while in HELD.
- o_Held  output  1  level; 1 while the FSM is in PRESS or HELD.
- o_Press_Count  output  8  number of presses detected since reset, modulo 256.

Behaviour:
- All outputs are registered. Every output changes only on a rising edge of i_CLK.
- Reset (i_RST = 1 sampled at an edge):
  - state becomes IDLE and count becomes 0;
  - o_Press, o_Release, o_Long, o_Repeat, o_Held and o_Press_Count all become 0;
  - reset overrides every other event on that edge;
  - reset in PRESS or HELD produces no o_Release.
- Pulse outputs default to 0 on every edge unless set by the rules below. Each pulse is therefore exactly one cycle wide.
- IDLE:
  - if i_Data = 1: o_Press <= 1, o_Press_Count <= o_Press_Count + 1 (wraps 255 -> 0), count <= 0, o_Held <= 1, next state PRESS;
  - otherwise stay in IDLE.
  - If i_Data is already 1 on the first edge after reset is released, it is treated as a press.
- PRESS:
  - if i_Data = 0: o_Release <= 1, o_Held <= 0, next state IDLE;
  - else if count == LONG_CYCLES-1: o_Long <= 1, count <= 0, next state HELD;
  - else count <= count + 1.
- HELD:
  - if i_Data = 0: o_Release <= 1, o_Held <= 0, next state IDLE;
  - else if count == REPEAT_CYCLES-1: o_Repeat <= 1, count <= 0;
  - else count <= count + 1.
- Latency, with the press sampled at edge k:
  - o_Press is high for the cycle after edge k;
  - o_Long fires at edge k+LONG_CYCLES if i_Data = 1 at every edge from k to k+LONG_CYCLES;
  - the first o_Repeat fires at edge k+LONG_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES edges.
- Release is sampled at edge r: o_Release is high for the cycle after edge r.
- Release has priority over the long/repeat decision on the same edge. On that edge o_Long / o_Repeat stay 0.
- No minimum gap between presses: IDLE -> PRESS is allowed on the edge right after a release.
- REPEAT_CYCLES = 1 gives o_Repeat high on every cycle in HELD.
- o_Long never coincides with o_Repeat.
- o_Press never coincides with o_Release, o_Long or o_Repeat.
- Count never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1. No overflow within CNT_W.

Test Plan:
- Common bench settings for all scenarios: LONG_CYCLES=4, REPEAT_CYCLES=3.
1. Reset state: hold i_RST=1 for 3 cycles with i_Data=1 -> all outputs 0. Release reset -> o_Press high for exactly one cycle after the first edge, o_Press_Count=1, o_Held=1.
2. Short press: i_Data high for 3 cycles, then low.
   - o_Press pulses once.
   - No o_Long.
   - o_Release pulses one cycle after the first low sample.
   - o_Held returns to 0.
   - o_Press_Count increments by 1.
3. Long + repeat: i_Data high for 14 edges starting at edge k.
   - o_Press after edge k.
   - o_Long after edge k+4.
   - o_Repeat after edges k+7, k+10, k+13.
   - Release at edge k+14 -> o_Release; no further o_Repeat.
4. Release/long collision: i_Data high at edges k..k+3, low at edge k+4 -> o_Release at k+4, o_Long never asserted, state IDLE.
5. Counter wrap: 256 back-to-back presses (1 cycle high, 1 cycle low) -> o_Press_Count reads 255 and then 0 after the 256th press. Every press and every release produces exactly one pulse each.
6. Reset mid-hold: assert i_RST while in HELD -> no o_Release, all outputs 0 on the next cycle. With i_Data still 1 after reset is released -> a new o_Press and o_Press_Count=1.
